// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory controller.
// Defining IMEM_CTRL_LOAD_EN makes the program loader (boot and run-time
// load paths) the default build; when undefined the controller boots straight
// into RUN and the RAM is read-only.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_W  = 10;
  localparam int unsigned IMEM_DATA_W  = 32;
  localparam logic [31:0] IMEM_NOP     = 32'h0000_0013;

`ifdef IMEM_CTRL_LOAD_EN
  localparam bit IMEM_LOAD_EN = 1'b1;
`else
  localparam bit IMEM_LOAD_EN = 1'b0;
`endif

  // Controller FSM states.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RUN   = 2'd3
  } imem_state_e;

  // Source of f_rdata for the most recent granted fetch.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_NOP  = 2'd1,
    SRC_RAM  = 2'd2
  } imem_rsrc_e;

endpackage

// File: rtl/imem_sram.sv
// imem_sram: single-port synchronous RAM with registered read data.
// Ports:
//   clk    - clock
//   en     - access enable (read when we=0, write when we=1)
//   we     - write enable
//   addr   - word index
//   wdata  - write data
//   rdata  - read data, valid the cycle after a read; holds otherwise
// The array has no reset; preload contents come from the memory macro's
// init image.
module imem_sram
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write or registered read; rdata is untouched by writes and idle cycles.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        r_mem[addr] <= wdata;
      end else begin
        rdata <= r_mem[addr];
      end
    end
  end

endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: arbitrates the single-port instruction RAM between the program
// loader (writes, LOAD state) and the IF stage (reads, RUN state), and holds
// the pipeline while the loader owns the memory.
// Build option: IMEM_CTRL_LOAD_EN (see imem_pkg) selects whether the loader
// path is enabled by default; the LOAD_EN parameter carries that choice.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   boot_req          - re-enter load mode from RUN
//   ld_valid/ld_ready - loader handshake; ld_addr/ld_data/ld_last payload
//   ld_count          - in-range words written this load (saturating)
//   f_req/f_addr      - fetch request and byte PC
//   f_gnt             - fetch accepted (combinational)
//   f_rvalid/f_rdata  - fetch response, one cycle after grant
//   f_err             - response is a fault (misaligned or out of range)
//   cpu_hold          - pipeline hold while not in RUN
module imem_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W   = IMEM_ADDR_W,
  parameter logic [31:0] NOP_WORD = IMEM_NOP,
  parameter bit          LOAD_EN  = IMEM_LOAD_EN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            boot_req,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [31:0]     ld_addr,
  input  logic [31:0]     ld_data,
  input  logic            ld_last,
  output logic [ADDR_W:0] ld_count,
  input  logic            f_req,
  input  logic [31:0]     f_addr,
  output logic            f_gnt,
  output logic            f_rvalid,
  output logic [31:0]     f_rdata,
  output logic            f_err,
  output logic            cpu_hold
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  imem_state_e       r_state;
  imem_state_e       w_state_nxt;
  logic              w_cnt_clr;
  logic [CNT_W-1:0]  r_ld_count;
  logic              r_rvalid;
  logic              r_err;
  imem_rsrc_e        r_src;

  logic              w_ld_in_rng;
  logic              w_f_fault;
  logic              w_wr;
  logic              w_rd;
  logic              w_ram_en;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [31:0]       w_ram_rdata;
  logic              w_unused_ok;

  // Byte-lane bits of the loader address carry no information.
  assign w_unused_ok = ^ld_addr[1:0];

  assign w_ld_in_rng = (ld_addr[31:ADDR_W+2] == '0);
  assign w_f_fault   = (f_addr[1:0] != 2'b00) || (f_addr[31:ADDR_W+2] != '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and state-decoded controls.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    ld_ready    = 1'b0;
    cpu_hold    = 1'b1;
    f_gnt       = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = LOAD_EN ? ST_LOAD : ST_RUN;
      end
      ST_LOAD: begin
        ld_ready = LOAD_EN;
        // ld_ready is 1 here, so ld_valid alone marks the handshake.
        if (ld_valid && ld_last) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        cpu_hold = 1'b0;
        f_gnt    = f_req;
        // A fetch granted in the same cycle still completes next cycle.
        if (LOAD_EN && boot_req) begin
          w_state_nxt = ST_LOAD;
          w_cnt_clr   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // RAM port: writes only in LOAD, reads only in RUN, never both.
  assign w_wr       = ld_valid & ld_ready & w_ld_in_rng;
  assign w_rd       = f_gnt & ~w_f_fault;
  assign w_ram_we   = LOAD_EN & w_wr;
  assign w_ram_en   = w_ram_we | w_rd;
  assign w_ram_addr = w_ram_we ? ld_addr[ADDR_W+1:2] : f_addr[ADDR_W+1:2];

  imem_sram #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_sram (
    .clk   (clk),
    .en    (w_ram_en),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (ld_data),
    .rdata (w_ram_rdata)
  );

  // Saturating count of words actually written during the current load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_count <= '0;
    end else if (w_cnt_clr) begin
      r_ld_count <= '0;
    end else if (w_ram_we && (r_ld_count != '1)) begin
      r_ld_count <= r_ld_count + CNT_W'(1);
    end
  end

  assign ld_count = r_ld_count;

  // Fetch response flags and data source, captured on each grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_src    <= SRC_ZERO;
    end else begin
      r_rvalid <= f_gnt;
      r_err    <= f_gnt & w_f_fault;
      if (f_gnt) begin
        r_src <= w_f_fault ? SRC_NOP : SRC_RAM;
      end
    end
  end

  // RAM read data holds between reads, so the mux also holds f_rdata.
  always_comb begin
    f_rdata = '0;
    case (r_src)
      SRC_NOP: f_rdata = NOP_WORD;
      SRC_RAM: f_rdata = w_ram_rdata;
      default: f_rdata = '0;
    endcase
  end

  assign f_rvalid = r_rvalid;
  assign f_err    = r_err;

endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: directed self-checking bench for imem_ctrl with the loader
// enabled and a 10-bit word index.
module tb_imem_ctrl;

  logic        clk;
  logic        rst;
  logic        boot_req;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;
  logic [10:0] ld_count;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        f_err;
  logic        cpu_hold;

  int n_vec;
  int n_miss;

  logic [31:0] prog [4] = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_0013};

  imem_ctrl #(
    .ADDR_W   (10),
    .NOP_WORD (32'h0000_0013),
    .LOAD_EN  (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .boot_req (boot_req),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_count (ld_count),
    .f_req    (f_req),
    .f_addr   (f_addr),
    .f_gnt    (f_gnt),
    .f_rvalid (f_rvalid),
    .f_rdata  (f_rdata),
    .f_err    (f_err),
    .cpu_hold (cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one loader word and complete its handshake; ld_valid stays high.
  task automatic load_word(input logic [31:0] a, input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    for (int k = 0; k < 8 && !ld_ready; k++) step();
    chk("ld_ready_hs", 32'(ld_ready), 32'd1);
    step();
  endtask

  // Single fetch: grant this cycle, response checked next cycle.
  task automatic fetch1(input string tag, input logic [31:0] a,
                        input logic [31:0] exp_d, input logic exp_e);
    f_req  = 1'b1;
    f_addr = a;
    #1;
    chk({tag, "_gnt"}, 32'(f_gnt), 32'd1);
    step();
    f_req = 1'b0;
    chk({tag, "_rvalid"}, 32'(f_rvalid), 32'd1);
    chk({tag, "_err"}, 32'(f_err), 32'(exp_e));
    chk({tag, "_rdata"}, f_rdata, exp_d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pcs [8];
    logic [31:0] exps [8];

    n_vec    = 0;
    n_miss   = 0;
    rst      = 1'b1;
    boot_req = 1'b0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    ld_last  = 1'b0;
    f_req    = 1'b1;
    f_addr   = '0;

    // Reset values with a fetch request pending.
    step();
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_ld_count", 32'(ld_count), 32'd0);
    chk("rst_f_gnt", 32'(f_gnt), 32'd0);
    chk("rst_f_rvalid", 32'(f_rvalid), 32'd0);
    chk("rst_f_rdata", f_rdata, 32'd0);
    chk("rst_f_err", 32'(f_err), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);

    // Release: BOOT for one cycle, then LOAD.
    step();
    rst   = 1'b0;
    f_req = 1'b0;
    #1;
    chk("boot_ld_ready", 32'(ld_ready), 32'd0);
    step();
    chk("load_ld_ready", 32'(ld_ready), 32'd1);

    // Boot load with an out-of-range word slipped in before the last one.
    load_word(32'h0, prog[0], 1'b0);
    load_word(32'h4, prog[1], 1'b0);
    load_word(32'h8, prog[2], 1'b0);
    chk("ld_count_3", 32'(ld_count), 32'd3);
    load_word(32'h8000, 32'hBAD0_BAD0, 1'b0);
    chk("ld_count_oor", 32'(ld_count), 32'd3);
    load_word(32'hC, prog[3], 1'b1);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    f_req    = 1'b1;
    f_addr   = 32'h0;
    #1;
    chk("drain_ld_count", 32'(ld_count), 32'd4);
    chk("drain_ld_ready", 32'(ld_ready), 32'd0);
    chk("drain_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("drain_f_gnt", 32'(f_gnt), 32'd0);
    f_req = 1'b0;
    step();
    chk("run_cpu_hold", 32'(cpu_hold), 32'd0);

    for (int i = 0; i < 4; i++) fetch1("boot_fetch", 32'(i * 4), prog[i], 1'b0);

    // Back-to-back fetches: grant every cycle, data one cycle behind.
    for (int i = 0; i < 8; i++) begin
      pcs[i]  = 32'((i % 4) * 4);
      exps[i] = prog[i % 4];
    end
    for (int i = 0; i < 8; i++) begin
      f_req  = 1'b1;
      f_addr = pcs[i];
      #1;
      chk("b2b_gnt", 32'(f_gnt), 32'd1);
      if (i > 0) begin
        chk("b2b_rvalid", 32'(f_rvalid), 32'd1);
        chk("b2b_rdata", f_rdata, exps[i-1]);
      end
      step();
    end
    f_req = 1'b0;
    chk("b2b_rvalid_last", 32'(f_rvalid), 32'd1);
    chk("b2b_rdata_last", f_rdata, exps[7]);
    step();
    chk("b2b_rvalid_idle", 32'(f_rvalid), 32'd0);
    chk("b2b_rdata_hold", f_rdata, exps[7]);

    // Faulting fetches return NOP with f_err.
    fetch1("fault_misalign", 32'h2, 32'h0000_0013, 1'b1);
    fetch1("fault_range", 32'h1000, 32'h0000_0013, 1'b1);
    step();
    chk("fault_rvalid_idle", 32'(f_rvalid), 32'd0);
    chk("fault_err_idle", 32'(f_err), 32'd0);
    chk("fault_rdata_hold", f_rdata, 32'h0000_0013);

    // Run-time reload requested together with a fetch.
    f_req    = 1'b1;
    f_addr   = 32'h4;
    boot_req = 1'b1;
    #1;
    chk("reload_gnt", 32'(f_gnt), 32'd1);
    step();
    boot_req = 1'b0;
    f_addr   = 32'h0;
    #1;
    chk("reload_rvalid", 32'(f_rvalid), 32'd1);
    chk("reload_rdata", f_rdata, prog[1]);
    chk("reload_f_gnt", 32'(f_gnt), 32'd0);
    chk("reload_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("reload_ld_count", 32'(ld_count), 32'd0);
    chk("reload_ld_ready", 32'(ld_ready), 32'd1);
    f_req = 1'b0;
    load_word(32'h0, 32'hDEAD_BEEF, 1'b1);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    #1;
    chk("reload_drain_count", 32'(ld_count), 32'd1);
    chk("reload_drain_hold", 32'(cpu_hold), 32'd1);
    step();
    fetch1("reload_fetch", 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Asynchronous reset kills an in-flight response.
    f_req  = 1'b1;
    f_addr = 32'h8;
    step();
    f_req = 1'b0;
    chk("kill_pre_rvalid", 32'(f_rvalid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("kill_rvalid", 32'(f_rvalid), 32'd0);
    chk("kill_rdata", f_rdata, 32'd0);
    chk("kill_cpu_hold", 32'(cpu_hold), 32'd1);
    step();
    rst = 1'b0;
    step();
    chk("kill_ld_ready", 32'(ld_ready), 32'd1);

    // Asynchronous reset after two of four load words.
    load_word(32'h10, 32'h1111_1111, 1'b0);
    load_word(32'h14, 32'h2222_2222, 1'b0);
    chk("midload_count", 32'(ld_count), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("midload_rst_ready", 32'(ld_ready), 32'd0);
    chk("midload_rst_count", 32'(ld_count), 32'd0);
    chk("midload_rst_hold", 32'(cpu_hold), 32'd1);
    ld_valid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    chk("midload_boot_ready", 32'(ld_ready), 32'd0);
    step();
    chk("midload_ready_back", 32'(ld_ready), 32'd1);
    chk("midload_count_back", 32'(ld_count), 32'd0);

    // Full reload; words written before the reset must survive.
    for (int i = 0; i < 4; i++) load_word(32'(i * 4), prog[i], (i == 3));
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    #1;
    chk("full_reload_count", 32'(ld_count), 32'd4);
    step();
    fetch1("full_reload_w0", 32'h0, prog[0], 1'b0);
    fetch1("kept_w4", 32'h10, 32'h1111_1111, 1'b0);
    fetch1("kept_w5", 32'h14, 32'h2222_2222, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
